// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: frame FSM states, error cause codes and
// the odd-parity check used by the frame deserializer and mouse controller.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2
   } ps2_state_t;

   localparam logic [1:0] PS2_ERR_NONE    = 2'b00;
   localparam logic [1:0] PS2_ERR_PARITY  = 2'b01;
   localparam logic [1:0] PS2_ERR_STOP    = 2'b10;
   localparam logic [1:0] PS2_ERR_TIMEOUT = 2'b11;

   // Index of the stop bit among the ten bits that follow the start bit.
   localparam logic [3:0] PS2_LAST_BIT = 4'd9;

   function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
      return ^{data, parity};
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchronizer plus glitch filter for one PS/2 line. The filtered level
// follows the input only after FILTER_LEN consecutive differing samples.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic filtered,
   output logic fall
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // Synchronize, count differing samples, and strobe on a filtered 1->0 change.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1    <= 1'b1;
         sync2    <= 1'b1;
         cnt      <= '0;
         filtered <= 1'b1;
         fall     <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         fall  <= 1'b0;
         if (sync2 == filtered) begin
            cnt <= '0;
         end else if (cnt == CW'(FILTER_LEN - 1)) begin
            filtered <= sync2;
            cnt      <= '0;
            fall     <= ~sync2;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: assembles start/8 data/parity/stop
// frames on filtered clock falls and reports good bytes or rejected frames.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       PS2Clk,
   input  logic       PS2Data,
   output logic [7:0] DataOut,
   output logic       DataValid,
   output logic       FrameErr,
   output logic [1:0] ErrCode,
   output logic       Busy
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          fall;
   logic          clk_level_unused;
   logic          data_s1;
   logic          data_sync;

   ps2_state_t    state;
   ps2_state_t    state_next;
   logic [3:0]    bit_cnt;
   logic [3:0]    bit_cnt_next;
   logic [9:0]    shreg;
   logic [9:0]    shreg_next;
   logic [TW-1:0] tcnt;
   logic [TW-1:0] tcnt_next;
   logic          load;
   logic          err;
   logic [1:0]    err_code;

   ps2_line_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_clk_filter (
      .clk      (Clk),
      .reset    (Reset),
      .raw      (PS2Clk),
      .filtered (clk_level_unused),
      .fall     (fall)
   );

   // Plain 2-FF synchronizer for the data line; it is only sampled on falls.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         data_s1   <= 1'b1;
         data_sync <= 1'b1;
      end else begin
         data_s1   <= PS2Data;
         data_sync <= data_s1;
      end
   end

   // Frame FSM next state; bits enter at the top so data lands in shreg[7:0].
   always_comb begin
      state_next   = state;
      bit_cnt_next = bit_cnt;
      shreg_next   = shreg;
      tcnt_next    = tcnt;
      load         = 1'b0;
      err          = 1'b0;
      err_code     = PS2_ERR_NONE;
      case (state)
         IDLE: begin
            tcnt_next    = '0;
            bit_cnt_next = 4'd0;
            if (fall && !data_sync) begin
               state_next = SHIFT;
               shreg_next = 10'd0;
            end else begin
               state_next = IDLE;
            end
         end
         SHIFT: begin
            if (fall) begin
               shreg_next   = {data_sync, shreg[9:1]};
               bit_cnt_next = bit_cnt + 4'd1;
               tcnt_next    = '0;
               if (bit_cnt == PS2_LAST_BIT) begin
                  state_next = CHECK;
               end else begin
                  state_next = SHIFT;
               end
            end else begin
               if (tcnt != TW'(TIMEOUT_CYCLES)) begin
                  tcnt_next = tcnt + TW'(1);
               end else begin
                  tcnt_next = tcnt;
               end
               if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  state_next = IDLE;
                  err        = 1'b1;
                  err_code   = PS2_ERR_TIMEOUT;
               end else begin
                  state_next = SHIFT;
               end
            end
         end
         CHECK: begin
            state_next = IDLE;
            if (!odd_parity_ok(shreg[7:0], shreg[8])) begin
               err      = 1'b1;
               err_code = PS2_ERR_PARITY;
            end else if (!shreg[9]) begin
               err      = 1'b1;
               err_code = PS2_ERR_STOP;
            end else begin
               load = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         bit_cnt   <= 4'd0;
         shreg     <= 10'd0;
         tcnt      <= '0;
         DataOut   <= 8'h00;
         DataValid <= 1'b0;
         FrameErr  <= 1'b0;
         ErrCode   <= PS2_ERR_NONE;
         Busy      <= 1'b0;
      end else begin
         state     <= state_next;
         bit_cnt   <= bit_cnt_next;
         shreg     <= shreg_next;
         tcnt      <= tcnt_next;
         DataValid <= load;
         FrameErr  <= err;
         Busy      <= (state_next != IDLE);
         if (load) begin
            DataOut <= shreg[7:0];
         end
         if (err) begin
            ErrCode <= err_code;
         end
      end
   end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Scoreboard bench for ps2_rx_frame: directed PS/2 frames push expected
// strobes into a queue; a monitor process pops and compares on each strobe.
`timescale 1ns/1ps
module tb_ps2_rx_frame;
   import ps2_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic [1:0] err_code;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
      logic [1:0] code;
      int         at;
   } exp_t;

   exp_t q[$];

   ps2_rx_frame #(
      .FILTER_LEN     (8),
      .TIMEOUT_CYCLES (500)
   ) dut (
      .Clk       (clk),
      .Reset     (reset),
      .PS2Clk    (ps2_clk),
      .PS2Data   (ps2_data),
      .DataOut   (data_out),
      .DataValid (data_valid),
      .FrameErr  (frame_err),
      .ErrCode   (err_code),
      .Busy      (busy)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   task automatic monitor_loop();
      exp_t e;
      forever begin
         @(negedge clk);
         if (data_valid || frame_err) begin
            if (q.size() == 0) begin
               chk("unexpected_strobe", {30'd0, frame_err, data_valid}, 0);
            end else begin
               e = q.pop_front();
               chk("strobe_kind", {30'd0, frame_err, data_valid}, e.is_err ? 2 : 1);
               chk("data_out", int'(data_out), int'(e.data));
               chk("err_code", int'(err_code), int'(e.code));
               chk("strobe_cycle", cyc, e.at);
            end
         end
      end
   endtask

   // Two low glitches (3 and 7 cycles) inside a high phase of PS2Clk.
   task automatic glitch_pair();
      repeat (12) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (12) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (7) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch,
                            input bit push, input exp_t e_in, input int lat);
      exp_t e;
      e = e_in;
      for (int i = 0; i < n; i++) begin
         ps2_data = bits[i];
         repeat (20) @(negedge clk);
         ps2_clk = 1'b0;
         if (push && i == n - 1) begin
            e.at = cyc + lat;
            q.push_back(e);
         end
         repeat (40) @(negedge clk);
         if (i == 0) chk("busy_after_start", int'(busy), 1);
         ps2_clk = 1'b1;
         if (glitch && (i == 3 || i == 7)) glitch_pair();
         repeat (20) @(negedge clk);
      end
   endtask

   task automatic frame(input logic [7:0] d, input logic par, input logic stp,
                        input bit glitch, input bit is_err,
                        input logic [7:0] dexp, input logic [1:0] cexp);
      exp_t e;
      e.is_err = is_err;
      e.data   = dexp;
      e.code   = cexp;
      e.at     = 0;
      send_bits({stp, par, d, 1'b0}, 11, glitch, 1'b1, e, 12);
      chk("busy_after_frame", int'(busy), 0);
   endtask

   initial begin
      exp_t e;
      reset    = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      fork
         monitor_loop();
      join_none
      repeat (5) @(negedge clk);
      chk("reset_data_out", int'(data_out), 0);
      chk("reset_valid", int'(data_valid), 0);
      chk("reset_frame_err", int'(frame_err), 0);
      chk("reset_err_code", int'(err_code), 0);
      chk("reset_busy", int'(busy), 0);
      reset = 1'b0;
      repeat (20) @(negedge clk);

      // good frames: 0xFA (6 ones, parity 1), 0x08 (1 one, parity 0)
      frame(8'hFA, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFA, PS2_ERR_NONE);
      frame(8'h08, 1'b0, 1'b1, 1'b0, 1'b0, 8'h08, PS2_ERR_NONE);
      // parity error, stop error, both (parity wins); DataOut holds 0x08
      frame(8'hFA, 1'b0, 1'b1, 1'b0, 1'b1, 8'h08, PS2_ERR_PARITY);
      frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 8'h08, PS2_ERR_STOP);
      frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 8'h08, PS2_ERR_PARITY);

      // timeout: start + 4 data bits, then lines idle high
      e.is_err = 1'b1;
      e.data   = 8'h08;
      e.code   = PS2_ERR_TIMEOUT;
      e.at     = 0;
      send_bits(11'b000_0000_1101 << 1, 5, 1'b0, 1'b1, e, 511);
      ps2_data = 1'b1;
      repeat (600) @(negedge clk);
      chk("busy_after_timeout", int'(busy), 0);
      frame(8'hAA, 1'b1, 1'b1, 1'b0, 1'b0, 8'hAA, PS2_ERR_TIMEOUT);

      // glitches in idle (data low, so a consumed fall would start a frame) and mid-frame
      ps2_data = 1'b0;
      glitch_pair();
      chk("busy_after_idle_glitch", int'(busy), 0);
      frame(8'h81, 1'b1, 1'b1, 1'b1, 1'b0, 8'h81, PS2_ERR_TIMEOUT);

      // reset after 6 bits discards the frame and restores reset values
      send_bits({1'b1, 1'b1, 8'h3C, 1'b0}, 6, 1'b0, 1'b0, e, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("busy_after_reset", int'(busy), 0);
      chk("data_out_after_reset", int'(data_out), 0);
      chk("err_code_after_reset", int'(err_code), 0);
      repeat (20) @(negedge clk);
      frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, PS2_ERR_NONE);

      for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #(20 * 60000);
      $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d, expected completion", cyc);
      $fatal(1, "watchdog");
   end

endmodule
